// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer.
// Each raw button is synchronised, then a per-channel FSM accepts a level
// change only after it has been stable for DEBOUNCE_TICKS prescaler ticks.
// Registered outputs give the debounced level and single-cycle press,
// release and long-press pulses.
module button_debounce #(
  parameter int unsigned N_BTN          = 4,
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned LONG_TICKS     = 1000
) (
  input  logic             Clk_i,
  input  logic             Rst_n_i,
  input  logic [N_BTN-1:0] Btn_i,
  output logic [N_BTN-1:0] Level_o,
  output logic [N_BTN-1:0] Press_o,
  output logic [N_BTN-1:0] Release_o,
  output logic [N_BTN-1:0] Long_o
);

  localparam int unsigned PS_W = $clog2(TICK_DIV) + 1;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int unsigned HD_W = $clog2(LONG_TICKS) + 1;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_TICKS);
  localparam logic [HD_W-1:0] HD_MAX  = HD_W'(LONG_TICKS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [PS_W-1:0]  pre_cnt;
  logic             tick;

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= Btn_i;
      sync2 <= sync1;
    end
  end

  // Shared prescaler: counts 0..TICK_DIV-1 and wraps
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PS_W'(1);
    end
  end

  assign tick = (pre_cnt == PS_LAST);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t          state;
    state_t          state_nxt;
    logic [DB_W-1:0] deb_cnt;
    logic [DB_W-1:0] deb_nxt;
    logic [DB_W-1:0] deb_inc;
    logic [HD_W-1:0] hold_cnt;
    logic [HD_W-1:0] hold_nxt;
    logic [HD_W-1:0] hold_inc;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            long_q;
    logic            level_nxt;
    logic            press_nxt;
    logic            release_nxt;
    logic            long_nxt;

    assign deb_inc  = deb_cnt + DB_W'(1);
    assign hold_inc = hold_cnt + HD_W'(1);

    // Next-state, counter and output-pulse decode; a sync change takes
    // priority over a coincident tick so that tick is not counted
    always_comb begin
      state_nxt   = state;
      deb_nxt     = deb_cnt;
      hold_nxt    = hold_cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      unique case (state)
        IDLE: begin
          if (sync2[g]) begin
            state_nxt = PRESS_WAIT;
            deb_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2[g]) begin
            state_nxt = IDLE;
          end else if (tick) begin
            deb_nxt = deb_inc;
            if (deb_inc == DB_MAX) begin
              state_nxt = PRESSED;
              hold_nxt  = '0;
              press_nxt = 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!sync2[g]) begin
            state_nxt = RELEASE_WAIT;
            deb_nxt   = '0;
          end else if (tick && (hold_cnt != HD_MAX)) begin
            hold_nxt = hold_inc;
            long_nxt = (hold_inc == HD_MAX);
          end
        end
        RELEASE_WAIT: begin
          if (sync2[g]) begin
            state_nxt = PRESSED;
          end else if (tick) begin
            deb_nxt = deb_inc;
            if (deb_inc == DB_MAX) begin
              state_nxt   = IDLE;
              release_nxt = 1'b1;
            end
          end
        end
      endcase
      level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    end

    // State, counters and registered outputs
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
      if (!Rst_n_i) begin
        state     <= IDLE;
        deb_cnt   <= '0;
        hold_cnt  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nxt;
        deb_cnt   <= deb_nxt;
        hold_cnt  <= hold_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
      end
    end

    assign Level_o[g]   = level_q;
    assign Press_o[g]   = press_q;
    assign Release_o[g] = release_q;
    assign Long_o[g]    = long_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with small tick/debounce values.
// A run-length reference model predicts every output on every cycle.
module tb_button_debounce;

  localparam int unsigned TD = 4;
  localparam int unsigned DT = 3;
  localparam int unsigned LT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] Level_o;
  logic [3:0] Press_o;
  logic [3:0] Release_o;
  logic [3:0] Long_o;

  button_debounce #(
    .N_BTN(4),
    .TICK_DIV(TD),
    .DEBOUNCE_TICKS(DT),
    .LONG_TICKS(LT)
  ) dut (
    .Clk_i(clk),
    .Rst_n_i(rst_n),
    .Btn_i(btn),
    .Level_o(Level_o),
    .Press_o(Press_o),
    .Release_o(Release_o),
    .Long_o(Long_o)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [3:0]  e_level, e_press, e_rel, e_long;
  logic [3:0]  m_s1, m_s2, m_prev;
  int unsigned m_pre;
  int unsigned dcount [4];
  int unsigned hold   [4];

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_press [4];
  int cnt_rel   [4];
  int cnt_long  [4];
  logic [3:0] first_press;
  int unsigned left [4];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_level = '0; e_press = '0; e_rel = '0; e_long = '0;
    m_s1 = '0; m_s2 = '0; m_prev = '0; m_pre = 0;
    for (int c = 0; c < 4; c++) begin
      dcount[c] = 0;
      hold[c]   = 0;
    end
  endtask

  // A change is accepted after DT ticks seen while the synchronised input
  // differed from the accepted level on this and the previous cycle.
  // Hold ticks count only while pressed and the input was high on both cycles.
  task automatic model_edge();
    logic [3:0] s;
    bit         tk;
    s  = m_s2;
    tk = (m_pre == TD - 1);
    e_press = '0; e_rel = '0; e_long = '0;
    for (int c = 0; c < 4; c++) begin
      if (s[c] != e_level[c]) begin
        if (m_prev[c] != e_level[c]) begin
          if (tk) begin
            dcount[c]++;
            if (dcount[c] == DT) begin
              e_level[c] = s[c];
              dcount[c]  = 0;
              if (s[c]) begin
                e_press[c] = 1'b1;
                hold[c]    = 0;
              end else begin
                e_rel[c] = 1'b1;
              end
            end
          end
        end else begin
          dcount[c] = 0;
        end
      end else begin
        dcount[c] = 0;
        if (e_level[c] && m_prev[c] && tk && hold[c] < LT) begin
          hold[c]++;
          if (hold[c] == LT) e_long[c] = 1'b1;
        end
      end
    end
    m_prev = s;
    m_s2   = m_s1;
    m_s1   = btn;
    m_pre  = (m_pre + 1) % TD;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      cnt_press[c] = 0;
      cnt_rel[c]   = 0;
      cnt_long[c]  = 0;
    end
    first_press = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge();
    check("level", Level_o, e_level);
    check("press", Press_o, e_press);
    check("release", Release_o, e_rel);
    check("long", Long_o, e_long);
    for (int c = 0; c < 4; c++) begin
      cnt_press[c] += int'(Press_o[c]);
      cnt_rel[c]   += int'(Release_o[c]);
      cnt_long[c]  += int'(Long_o[c]);
    end
    if (Press_o != '0 && first_press == '0) first_press = Press_o;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_level", Level_o, 4'b0000);
    check("rst_press", Press_o, 4'b0000);
    check("rst_release", Release_o, 4'b0000);
    check("rst_long", Long_o, 4'b0000);
    model_reset();
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    model_reset();
    clear_counts();
    cycles(3);
    rst_n = 1'b1;
    cycles(3);

    // clean press on channel 0
    clear_counts();
    btn[0] = 1'b1;
    cycles(20);
    check_int("clean_press0", cnt_press[0], 1);
    check_int("clean_rel0", cnt_rel[0], 0);
    check_int("clean_long0", cnt_long[0], 0);
    check("clean_level", Level_o, 4'b0001);

    // short glitch on channel 1 is rejected
    clear_counts();
    btn[1] = 1'b1;
    cycles(5);
    btn[1] = 1'b0;
    cycles(20);
    check_int("bounce_pulses1", cnt_press[1] + cnt_rel[1] + cnt_long[1], 0);
    check("bounce_level1", {3'b000, Level_o[1]}, 4'b0000);

    // long press on channel 2
    clear_counts();
    btn[2] = 1'b1;
    cycles(60);
    check_int("long_press2", cnt_press[2], 1);
    check_int("long_long2", cnt_long[2], 1);
    cycles(40);
    check_int("long_once2", cnt_long[2], 1);

    // release bounce on channel 0
    clear_counts();
    btn[0] = 1'b0;
    cycles(3);
    btn[0] = 1'b1;
    cycles(1);
    btn[0] = 1'b0;
    cycles(25);
    check_int("relb_press0", cnt_press[0], 0);
    check_int("relb_rel0", cnt_rel[0], 1);

    btn = '0;
    cycles(25);

    // all channels pressed together
    clear_counts();
    btn = 4'b1111;
    cycles(20);
    check("simul_press", first_press, 4'b1111);
    btn = '0;
    cycles(25);

    // reset while channel 3 is held
    btn = 4'b1000;
    cycles(20);
    check("pre_rst_level", Level_o, 4'b1000);
    do_reset();
    clear_counts();
    cycles(20);
    check_int("post_rst_press3", cnt_press[3], 1);
    check("post_rst_level", Level_o, 4'b1000);

    // randomized toggling with varying hold lengths
    for (int c = 0; c < 4; c++) left[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (left[c] == 0) begin
          btn[c]  = ~btn[c];
          left[c] = $urandom_range(1, 30);
        end else begin
          left[c]--;
        end
      end
      if (i == 750) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
